// File: rtl/ht16d35a_spi_sequencer.sv
// Two-requester arbiter and transaction sequencer for the HT16D35A 3-wire
// SPI controller. Requester 0 carries control commands and requester 1 carries
// display-RAM writes. The block waits out the power-up time after reset, then
// latches each accepted command and launches it. It tracks the controller busy
// handshake with a timeout and keeps a minimum idle gap between transactions.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// STARTUP    | power-up wait after reset release
// IDLE       | arbitrate; the granted requester sees ready
// LAUNCH     | one-cycle spi_activate pulse
// WAIT_BUSY  | waiting for the controller to raise busy (timeout guarded)
// WAIT_DONE  | controller busy; waiting for busy to fall
// DONE       | one-cycle done pulse to the owner
// GAP        | enforced idle gap before the next grant

module ht16d35a_spi_sequencer #(
    parameter int NUM_SELECTS    = 2,
    parameter int OUT_BYTES      = 8,
    parameter int OUT_BYTES_SZ   = $clog2(OUT_BYTES),
    parameter int POWERUP_CYCLES = 50000,
    parameter int GAP_CYCLES     = 100,
    parameter int ACK_TIMEOUT    = 16,
    parameter int MAX_CONSEC     = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [NUM_SELECTS-1:0]     req0_cs,
    input  logic [8*OUT_BYTES-1:0]     req0_data,
    input  logic [OUT_BYTES_SZ-1:0]    req0_count,
    output logic                       req0_done,

    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [NUM_SELECTS-1:0]     req1_cs,
    input  logic [8*OUT_BYTES-1:0]     req1_data,
    input  logic [OUT_BYTES_SZ-1:0]    req1_count,
    output logic                       req1_done,

    input  logic                       spi_busy,
    output logic                       spi_activate,
    output logic [NUM_SELECTS-1:0]     spi_cs,
    output logic [8*OUT_BYTES-1:0]     spi_data,
    output logic [OUT_BYTES_SZ-1:0]    spi_count,
    output logic                       timeout_err,
    output logic                       startup_done
);

    localparam int TMR_MAX_A = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > ACK_TIMEOUT) ? TMR_MAX_A : ACK_TIMEOUT;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam int CON_W     = $clog2(MAX_CONSEC + 1);

    // Terminal counts: each timed state lasts exactly N cycles, counting 0..N-1.
    localparam logic [TMR_W-1:0] PWR_TC = TMR_W'(POWERUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_TC = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACK_TC = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [CON_W-1:0] CON_MAX = CON_W'(MAX_CONSEC);

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_IDLE      = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5,
        ST_GAP       = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [CON_W-1:0]   consec;
    logic               owner;
    logic               gnt0, gnt1;
    logic               acc0, acc1;
    logic               set_timeout;
    logic               set_startup;

    // Fairness: req0 normally wins, but req1 gets a turn once req0 has taken
    // MAX_CONSEC grants in a row while req1 waits.
    always_comb begin
        gnt1 = req1_valid && (!req0_valid || (consec >= CON_MAX));
        gnt0 = req0_valid && !gnt1;
    end

    // Next-state, timer and handshake decode.
    always_comb begin
        state_nxt    = state;
        tmr_nxt      = '0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        acc0         = 1'b0;
        acc1         = 1'b0;
        set_timeout  = 1'b0;
        set_startup  = 1'b0;
        spi_activate = 1'b0;
        req0_done    = 1'b0;
        req1_done    = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (tmr == PWR_TC) begin
                    state_nxt   = ST_IDLE;
                    set_startup = 1'b1;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            ST_IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                acc0       = gnt0;
                acc1       = gnt1;
                if (gnt0) begin
                    state_nxt = (req0_count == '0) ? ST_DONE : ST_LAUNCH;
                end else if (gnt1) begin
                    state_nxt = (req1_count == '0) ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                spi_activate = 1'b1;
                state_nxt    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmr == ACK_TC) begin
                    state_nxt   = ST_DONE;
                    set_timeout = 1'b1;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi_busy) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                req0_done = (owner == 1'b0);
                req1_done = (owner == 1'b1);
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (tmr == GAP_TC) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_STARTUP;
            end
        endcase
    end

    // State, timer, arbitration history and latched transaction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_STARTUP;
            tmr          <= '0;
            consec       <= '0;
            owner        <= 1'b0;
            spi_cs       <= '0;
            spi_data     <= '0;
            spi_count    <= '0;
            timeout_err  <= 1'b0;
            startup_done <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (acc0) begin
                owner     <= 1'b0;
                spi_cs    <= req0_cs;
                spi_data  <= req0_data;
                spi_count <= req0_count;
                if (consec < CON_MAX) begin
                    consec <= consec + 1'b1;
                end
            end else if (acc1) begin
                owner     <= 1'b1;
                spi_cs    <= req1_cs;
                spi_data  <= req1_data;
                spi_count <= req1_count;
                consec    <= '0;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
            if (set_startup) begin
                startup_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ht16d35a_spi_sequencer.sv
// Directed bench for ht16d35a_spi_sequencer with shortened power-up and gap times.
module tb_ht16d35a_spi_sequencer;

    localparam int P  = 40;
    localparam int G  = 10;
    localparam int NS = 2;
    localparam int OB = 8;
    localparam int OS = 3;

    logic              clk;
    logic              reset;
    logic              req0_valid, req0_ready, req0_done;
    logic [NS-1:0]     req0_cs;
    logic [8*OB-1:0]   req0_data;
    logic [OS-1:0]     req0_count;
    logic              req1_valid, req1_ready, req1_done;
    logic [NS-1:0]     req1_cs;
    logic [8*OB-1:0]   req1_data;
    logic [OS-1:0]     req1_count;
    logic              spi_busy, spi_activate;
    logic [NS-1:0]     spi_cs;
    logic [8*OB-1:0]   spi_data;
    logic [OS-1:0]     spi_count;
    logic              timeout_err, startup_done;

    int errors = 0;
    int checks = 0;

    ht16d35a_spi_sequencer #(
        .NUM_SELECTS(NS), .OUT_BYTES(OB), .OUT_BYTES_SZ(OS),
        .POWERUP_CYCLES(P), .GAP_CYCLES(G), .ACK_TIMEOUT(16), .MAX_CONSEC(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cs(req0_cs),
        .req0_data(req0_data), .req0_count(req0_count), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cs(req1_cs),
        .req1_data(req1_data), .req1_count(req1_count), .req1_done(req1_done),
        .spi_busy(spi_busy), .spi_activate(spi_activate), .spi_cs(spi_cs),
        .spi_data(spi_data), .spi_count(spi_count),
        .timeout_err(timeout_err), .startup_done(startup_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int who);
        who = -1;
        for (int n = 0; n < 200; n++) begin
            if (req0_ready) who = 0;
            else if (req1_ready) who = 1;
            if (who >= 0) break;
            tick();
        end
        check("ready_seen", 64'(req0_ready | req1_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  who;
        logic ok;

        reset      = 1'b0;
        req0_valid = 1'b0; req0_cs = 2'b10; req0_data = 64'hA5A5_A5A5_A500_0335; req0_count = 3'd3;
        req1_valid = 1'b0; req1_cs = 2'b01; req1_data = 64'h1122_3344_5566_7788; req1_count = 3'd0;
        spi_busy   = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // reset state
        check("rst_startup_done", 64'(startup_done), 64'd0);
        check("rst_activate",     64'(spi_activate), 64'd0);
        check("rst_spi_data",     spi_data,          64'd0);
        check("rst_ready0",       64'(req0_ready),   64'd0);
        check("rst_timeout",      64'(timeout_err),  64'd0);

        // 1: power-up wait with req0 pending
        req0_valid = 1'b1;
        reset      = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < P; i++) begin
            if (req0_ready || startup_done) ok = 1'b0;
            tick();
        end
        check("powerup_quiet",   64'(ok),           64'd1);
        check("startup_done_up", 64'(startup_done), 64'd1);
        check("first_ready0",    64'(req0_ready),   64'd1);
        check("first_ready1",    64'(req1_ready),   64'd0);

        // 2: req0 3-byte command with 20-cycle busy
        tick();
        check("launch_pulse",  64'(spi_activate), 64'd1);
        check("launch_cs",     64'(spi_cs),       64'h2);
        check("launch_count",  64'(spi_count),    64'd3);
        check("launch_data",   spi_data,          64'hA5A5_A5A5_A500_0335);
        check("launch_noready",64'(req0_ready),   64'd0);
        req0_valid = 1'b0;
        tick();
        check("activate_single", 64'(spi_activate), 64'd0);
        tick();
        spi_busy = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req0_done || spi_activate) ok = 1'b0;
            tick();
        end
        spi_busy = 1'b0;
        check("busy_quiet",  64'(ok),        64'd1);
        check("hold_cs",     64'(spi_cs),    64'h2);
        check("hold_count",  64'(spi_count), 64'd3);
        tick();
        check("done0_pulse", 64'(req0_done),   64'd1);
        check("done0_notmo", 64'(timeout_err), 64'd0);

        // 5: req1 zero-length command, presented during the gap
        req1_valid = 1'b1;
        tick();
        check("done0_single", 64'(req0_done), 64'd0);
        ok = 1'b1;
        for (int i = 0; i < G; i++) begin
            if (req0_ready || req1_ready) ok = 1'b0;
            tick();
        end
        check("gap_quiet",     64'(ok),         64'd1);
        check("gap_ready1",    64'(req1_ready), 64'd1);
        check("gap_ready0",    64'(req0_ready), 64'd0);
        tick();
        check("zero_done1",    64'(req1_done),    64'd1);
        check("zero_done0",    64'(req0_done),    64'd0);
        check("zero_noact",    64'(spi_activate), 64'd0);
        check("zero_count",    64'(spi_count),    64'd0);
        check("zero_cs",       64'(spi_cs),       64'h1);
        check("zero_data",     spi_data,          64'h1122_3344_5566_7788);
        req1_valid = 1'b0;
        tick();
        check("zero_done_end", 64'(req1_done),    64'd0);
        check("zero_noact2",   64'(spi_activate), 64'd0);

        // 3: both valid held, zero-length commands
        req0_count = 3'd0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int g = 0; g < 10; g++) begin
            wait_ready(who);
            check($sformatf("grant_%0d", g), 64'(who), (g % 5 == 4) ? 64'd1 : 64'd0);
            tick();
            check($sformatf("grant_done_%0d", g), 64'(who == 1 ? req1_done : req0_done), 64'd1);
            check($sformatf("grant_noact_%0d", g), 64'(spi_activate), 64'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // 4: controller never answers
        req0_count = 3'd2;
        req0_valid = 1'b1;
        wait_ready(who);
        check("tmo_grant", 64'(who), 64'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        repeat (15) tick();
        check("tmo_not_yet", 64'(timeout_err), 64'd0);
        check("tmo_no_done", 64'(req0_done),   64'd0);
        tick();
        check("tmo_flag",    64'(timeout_err), 64'd1);
        check("tmo_done",    64'(req0_done),   64'd1);
        req1_count = 3'd3;
        req1_valid = 1'b1;
        tick();
        check("tmo_done_end", 64'(req0_done), 64'd0);
        repeat (G) tick();
        check("tmo_idle_ready", 64'(req1_ready),  64'd1);
        check("tmo_sticky",     64'(timeout_err), 64'd1);

        // 6: reset during WAIT_DONE
        tick();
        check("r6_launch", 64'(spi_activate), 64'd1);
        tick();
        spi_busy = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("r6_act",     64'(spi_activate), 64'd0);
        check("r6_cs",      64'(spi_cs),       64'd0);
        check("r6_data",    spi_data,          64'd0);
        check("r6_count",   64'(spi_count),    64'd0);
        check("r6_ready",   64'({req0_ready, req1_ready}), 64'd0);
        check("r6_done",    64'({req0_done, req1_done}),   64'd0);
        check("r6_timeout", 64'(timeout_err),  64'd0);
        check("r6_startup", 64'(startup_done), 64'd0);
        tick();
        spi_busy = 1'b0;
        tick();
        reset = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < P; i++) begin
            if (req1_done || req0_done || req1_ready || startup_done) ok = 1'b0;
            tick();
        end
        check("r6_restart_quiet", 64'(ok),           64'd1);
        check("r6_startup_up",    64'(startup_done), 64'd1);
        check("r6_ready1",        64'(req1_ready),   64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ht16d35a_spi_sequencer.md
Name: ht16d35a_spi_sequencer

Overview:
- Two-requester arbiter and transaction sequencer in front of the HT16D35A 3-wire SPI controller.
- Requester 0 carries control/configuration commands; requester 1 carries bulk display-RAM writes.
- The block enforces a power-up wait after reset and a minimum idle gap between SPI transactions.
- It latches each command, launches it, and tracks the controller's busy handshake, with a timeout.

Parameters:
NUM_SELECTS, 2, number of chip-select lines
OUT_BYTES, 8, maximum bytes per transaction
OUT_BYTES_SZ, $clog2(OUT_BYTES), byte-count width
POWERUP_CYCLES, 50000, clk cycles to wait after reset release before the first grant (1 ms at 50 MHz)
GAP_CYCLES, 100, minimum clk cycles between one transaction's busy fall and the next launch
ACK_TIMEOUT, 16, cycles allowed for spi_busy to rise after launch
MAX_CONSEC, 4, consecutive req0 grants allowed while req1 is pending

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a command
req0_ready  output  1  requester 0 command accepted this cycle (when req0_valid)
req0_cs  input  NUM_SELECTS  chip-select pattern for the command
req0_data  input  8 x OUT_BYTES  command bytes, index 0 sent first
req0_count  input  OUT_BYTES_SZ  number of bytes to send
req0_done  output  1  one-cycle pulse when requester 0's transaction completes
req1_valid/req1_ready/req1_cs/req1_data/req1_count/req1_done  as above, for requester 1
spi_busy  input  1  busy output of the SPI controller
spi_activate  output  1  one-cycle launch pulse to the controller
spi_cs  output  NUM_SELECTS  latched chip-select pattern
spi_data  output  8 x OUT_BYTES  latched bytes
spi_count  output  OUT_BYTES_SZ  latched byte count
timeout_err  output  1  sticky flag: controller never asserted busy; cleared only by reset
startup_done  output  1  high once the power-up wait has elapsed

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state STARTUP; all counters 0
  - spi_activate=0, spi_cs/spi_data/spi_count=0
  - req*_ready=0, req*_done=0, timeout_err=0, startup_done=0
  - Reset asserted mid-transaction aborts it immediately; no done pulse is issued.
- STARTUP: count POWERUP_CYCLES cycles, then set startup_done=1 (it stays 1) and go to IDLE.
- IDLE arbitration, combinational within the cycle:
  - Grant req0 if req0_valid, unless consec>=MAX_CONSEC and req1_valid, in which case grant req1.
  - Otherwise grant req1 if req1_valid.
  - Only the granted requester sees ready=1. Ready is never high outside IDLE.
- Handshake (ready & valid):
  - Latch cs, data and count into the spi_* registers.
  - Record the owner.
  - consec increments on a req0 grant (saturating at MAX_CONSEC) and clears to 0 on any req1 grant.
  - If count==0: go to DONE (no SPI activity). Otherwise go to LAUNCH.
- LAUNCH: spi_activate=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY:
  - spi_busy=1 goes to WAIT_DONE.
  - After ACK_TIMEOUT cycles without busy: set timeout_err and go to DONE; the owner's done pulse still fires.
- WAIT_DONE: wait for spi_busy=0, then go to DONE.
- DONE: pulse the owner's req*_done for one cycle, then go to GAP.
- GAP:
  - Count GAP_CYCLES, then go to IDLE.
  - A count==0 command also passes through GAP.
- spi_cs, spi_data and spi_count stay stable from the handshake cycle until the next handshake. They are not cleared after completion.
- Minimum accept-to-accept spacing is 1 (accept) + 1 (LAUNCH) + busy duration + ACK latency + 1 (DONE) + GAP_CYCLES.
- spi_busy is ignored in IDLE, STARTUP and GAP.
- Both valids high with consec<MAX_CONSEC: req0 wins.
- A requester that deasserts valid before receiving ready is simply not served; no state is kept for it.

Test Plan:
1. Reset release, req0_valid=1 held → req0_ready stays 0 for POWERUP_CYCLES cycles, startup_done rises, req0_ready=1 on the next cycle.
2. req0: cs=2'b10, data[0..2]=8'h35,8'h03,8'h00, count=3; model busy high for 20 cycles starting 2 cycles after activate → spi_activate is a single pulse one cycle after accept; spi_* hold those values; req0_done pulses one cycle after busy falls; next ready is at least GAP_CYCLES later.
3. Both valids held continuously → grant order req0 x4, req1, req0 x4, req1; consec resets on each req1 grant.
4. Controller model never raises busy → after 16 cycles in WAIT_BUSY, timeout_err=1, done pulses, and the block returns to IDLE after the gap; timeout_err remains 1.
5. req1 with count=0 → accepted, no spi_activate, req1_done pulses the following cycle.
6. Assert reset during WAIT_DONE → all outputs are at reset values in the same cycle, no done pulse, and the block re-enters STARTUP.
